// File: rtl/clock_divider.sv
// Parameterised divider: a counter that returns to zero at MAX_COUNT toggles a
// registered square-wave output, giving f_clk / (2*(MAX_COUNT+1)).
module clock_divider #(
    parameter int unsigned     COUNT_WIDTH = 32'd32,
    parameter longint unsigned MAX_COUNT   = 64'd6000000
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(MAX_COUNT);

    generate
        if (COUNT_WIDTH < 32'd1) begin : g_bad_width
            $error("clock_divider: COUNT_WIDTH must be at least 1");
        end else if ((COUNT_WIDTH < 32'd64) && (MAX_COUNT >= (64'd1 << COUNT_WIDTH))) begin : g_bad_max
            $error("clock_divider: MAX_COUNT does not fit in COUNT_WIDTH bits");
        end
    endgenerate

    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] count_s;
    logic                   out_r;
    logic                   out_s;

    // Next state: the terminal compare, never counter overflow, returns count to zero.
    always_comb begin
        count_s = count_r;
        out_s   = out_r;
        if (count_r == TERMINAL) begin
            count_s = '0;
            out_s   = ~out_r;
        end else begin
            count_s = count_r + COUNT_WIDTH'(1'b1);
            out_s   = out_r;
        end
    end

    // State registers; rst low clears both immediately and suppresses counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            out_r   <= 1'b0;
        end else begin
            count_r <= count_s;
            out_r   <= out_s;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: three instances (5/4-bit, 0/1-bit, 15/4-bit) checked
// against a reference model through an expectation queue.
`timescale 1ns/10ps
module tb_clock_divider;

    logic clk;
    logic rst;
    logic out5;
    logic out0;
    logic out15;

    int checks;
    int failures;

    typedef struct packed {
        logic       o5;
        logic [3:0] c5;
        logic       o0;
        logic       o15;
        logic [3:0] c15;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m5c;
    logic       m5o;
    logic       m0o;
    logic [3:0] m15c;
    logic       m15o;

    clock_divider #(.COUNT_WIDTH(32'd4), .MAX_COUNT(64'd5))  dut5  (.clk(clk), .rst(rst), .out(out5));
    clock_divider #(.COUNT_WIDTH(32'd1), .MAX_COUNT(64'd0))  dut0  (.clk(clk), .rst(rst), .out(out0));
    clock_divider #(.COUNT_WIDTH(32'd4), .MAX_COUNT(64'd15)) dut15 (.clk(clk), .rst(rst), .out(out15));

    initial begin
        clk = 1'b0;
        forever #41.67 clk = ~clk;
    end

    function automatic exp_t observe();
        exp_t o;
        o.o5  = out5;
        o.c5  = dut5.count_r;
        o.o0  = out0;
        o.o15 = out15;
        o.c15 = dut15.count_r;
        return o;
    endfunction

    task automatic model_reset();
        m5c  = 4'd0;
        m5o  = 1'b0;
        m0o  = 1'b0;
        m15c = 4'd0;
        m15o = 1'b0;
    endtask

    // Wait for one rising edge, advance the model with the rst level sampled there.
    task automatic drive_edge();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m5c == 4'd5) begin
                m5c = 4'd0;
                m5o = ~m5o;
            end else begin
                m5c = m5c + 4'd1;
            end
            m0o = ~m0o;
            if (m15c == 4'd15) begin
                m15c = 4'd0;
                m15o = ~m15o;
            end else begin
                m15c = m15c + 4'd1;
            end
        end
        sb.push_back({m5o, m5c, m0o, m15o, m15c});
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o;
        #5;
        model_reset();
        sb.push_back({m5o, m5c, m0o, m15o, m15c});
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_state: got %b want %b", o, e);
        end
        #6;
        rst = 1'b1;
    endtask

    task automatic test_period();
        exp_t e;
        exp_t o;
        logic p5, p0, p15;
        int   l5, l0, l15;
        p5 = 1'b0; p0 = 1'b0; p15 = 1'b0;
        l5 = 0; l0 = 0; l15 = 0;
        for (int i = 1; i <= 120; i++) begin
            drive_edge();
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL period edge %0d: got %b want %b", i, o, e);
            end
            if (o.o5 !== p5) begin
                checks++;
                if (i - l5 != 6) begin
                    failures++;
                    $display("FAIL half_period_div5 edge %0d: got %0d want 6", i, i - l5);
                end
                l5 = i;
                p5 = o.o5;
            end
            if (o.o0 !== p0) begin
                checks++;
                if (i - l0 != 1) begin
                    failures++;
                    $display("FAIL half_period_div0 edge %0d: got %0d want 1", i, i - l0);
                end
                l0 = i;
                p0 = o.o0;
            end
            if (o.o15 !== p15) begin
                checks++;
                if (i - l15 != 16) begin
                    failures++;
                    $display("FAIL half_period_div15 edge %0d: got %0d want 16", i, i - l15);
                end
                l15 = i;
                p15 = o.o15;
            end
        end
        checks++;
        if (l15 != 112) begin
            failures++;
            $display("FAIL toggle_count_div15: got last toggle %0d want 112", l15);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        exp_t o;
        bit   found;
        int   n;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            drive_edge();
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_reset_approach %0d: got %b want %b", i, o, e);
            end
            found = (m5o == 1'b1) && (m5c == 4'd3);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reset_setup: got no out=1/count=3 state want one within 24 edges");
        end
        #20;
        rst = 1'b0;
        #1;
        model_reset();
        sb.push_back({m5o, m5c, m0o, m15o, m15c});
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL mid_reset_immediate: got %b want %b", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_reset_hold %0d: got %b want %b", i, o, e);
            end
        end
        #20;
        rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            drive_edge();
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_reset_resume %0d: got %b want %b", i, o, e);
            end
            if (o.o5 === 1'b1) n = i;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL mid_reset_first_toggle: got edge %0d want 6", n);
        end
    endtask

    task automatic test_release_on_edge();
        exp_t e;
        exp_t o;
        int   n;
        #20;
        rst = 1'b0;
        drive_edge();
        #1;
        void'(sb.pop_front());
        // Release just after this edge so it is sampled low and must not count.
        drive_edge();
        #0.01;
        rst = 1'b1;
        #1;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL release_edge_no_count: got %b want %b", o, e);
        end
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            drive_edge();
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL release_edge_run %0d: got %b want %b", i, o, e);
            end
            if (o.o5 === 1'b1) n = i;
        end
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL release_edge_first_toggle: got edge %0d want 6", n);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        model_reset();
        test_reset();
        test_period();
        test_mid_reset();
        test_release_on_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
